multi_clock_tree_gen: RTL and testbench
=======================================

# multi_clock_tree_gen

Parametrised successor to the fixed single-channel tick/clock pair. It generates NR_CHANNELS independent derived clocks from one global clock through a shared tick prescaler. High/low durations are runtime-programmable per channel, and run/stop/single-step control stops cleanly at phase boundaries. It sits between the board clock and the generated `main` circuit, feeding its clock-tree inputs and the debug/stop-lamp logic.

## Interface
- NR_CHANNELS, 2: number of derived clock channels (1..16).
- TICK_BITS, 3: prescaler counter width.
- RELOAD_VALUE, 4: prescaler reload; one tick every RELOAD_VALUE+1 cycles.
- CNT_BITS, 8: width of the high/low duration fields, in ticks.
- DEF_HIGH, 1 / DEF_LOW, 1: reset duration of every channel.
- RUN_AT_RESET, 1: 1 = RUNNING after reset, 0 = STOPPED.
- fpgaGlobalClock  in  1  sole clock.
- reset_i  in  1  asynchronous, active-high reset.
- run_i  in  1  level; 1 requests free-running clocks.
- halt_i  in  1  level; forces stop, priority over run_i and step_i (driven from stop lamp).
- step_i  in  1  single-cycle pulse; one ch0 period while STOPPED.
- cfg_we_i  in  1  config write strobe.
- cfg_ch_i  in  CH_BITS=max(1,clog2(NR_CHANNELS))  target channel.
- cfg_high_i, cfg_low_i  in  CNT_BITS  new durations in ticks.
- clk_o  out  NR_CHANNELS  derived clock levels.
- rise_o, fall_o  out  NR_CHANNELS  one-cycle edge strobes.
- tick_o  out  1  prescaler tick.
- state_o  out  2  0 STOPPED, 1 RUNNING, 2 STEPPING, 3 STOPPING.

## Operation
- Prescaler: cnt resets to RELOAD_VALUE.
  - When cnt==0: tick is asserted combinationally and cnt reloads.
  - Otherwise: cnt decrements.
  - RELOAD_VALUE=0 gives a tick every cycle.
- Channel state: level (reset 0), remaining count pc (reset DEF_LOW), shadow high/low registers (reset DEF_HIGH/DEF_LOW).
  - A stored duration of 0 is treated as 1.
- Channel advance = tick AND one of:
  - state is RUNNING or STEPPING, or
  - state is STOPPING and level==1.
- On advance with pc==1:
  - level toggles.
  - pc loads the opposite phase's shadow value.
  - rise_o or fall_o pulses.
- On advance with pc>1: pc decrements.
- Config write: updates the shadow registers only. The new value takes effect at the next phase load; the current phase is never truncated. Writes with cfg_ch_i>=NR_CHANNELS are ignored.
- FSM transitions:
  - STOPPED→RUNNING: run_i & !halt_i.
  - STOPPED→STEPPING: step_i & !run_i & !halt_i.
  - RUNNING→STOPPING: !run_i | halt_i.
  - STEPPING→STOPPING: ch0 fall_o, or halt_i.
  - STOPPING→STOPPED: all levels 0.
  - STOPPING→RUNNING: run_i & !halt_i; the stop is abandoned.
- STEPPING: ch0 must produce exactly one rise then one fall. Other channels advance alongside it.
- STOPPING freezes low channels and lets high channels finish their high phase. A truncated high pulse is never produced.
- step_i is ignored outside STOPPED.

## Timing
- Reset values:
  - clk_o, rise_o, fall_o, tick_o = 0.
  - state_o = RUN_AT_RESET ? 1 : 0.
- Reset asserted mid-operation clears everything immediately (asynchronous). No edge strobe is emitted.
- Edge k is the k-th rising edge after reset release. With RELOAD=4:
  - tick_o is high after edges 4, 9, 14, …
  - A toggling advance appears on clk_o at the next edge (edge 5, 10, …).
- rise_o/fall_o are high for exactly the one cycle in which clk_o first shows its new level.
- Period in cycles = (high+low)·(RELOAD_VALUE+1).
- FSM updates on the clock edge following the qualifying input. In the same cycle, an advance uses the pre-transition state.

## Test plan
- RELOAD=4, defaults, RUN_AT_RESET=1:
  - ch0 rises at edge 5, falls at 10, rises at 15.
  - rise_o is high only in cycles 5, 15, …; fall_o only in cycle 10, ….
- While running, write ch1 high=3 low=2 mid-high-phase:
  - The current phase keeps its old length.
  - Thereafter ch1 is high 15 cycles and low 10.
- ch0 high=4: drop run_i 1 cycle after ch0 rises:
  - state_o=3, ch0 stays high to the end of its 4 ticks and falls.
  - Then state_o=0, and no further edges for 200 cycles.
- From STOPPED, pulse step_i:
  - Exactly one rise_o[0] and one fall_o[0] occur, then state_o returns 0.
  - step_i with halt_i=1 does nothing.
- Assert reset_i while ch0 high:
  - clk_o=0 at once and no fall_o.
  - After release, timing repeats as in the first scenario.
- Write cfg_high_i=0 to ch0: high lasts 1 tick. Write cfg_ch_i=NR_CHANNELS: no channel changes.

Source files
------------

// File: rtl/multi_clock_tree_gen.sv
`default_nettype none
// ============================================================================
//  Module   : multi_clock_tree_gen
//  Purpose  : Generates NR_CHANNELS derived clock levels from one global clock.
//             A shared prescaler produces a tick every RELOAD_VALUE+1 cycles.
//             Each channel counts high/low phases in ticks. The phase lengths
//             are programmable per channel through shadow registers. A
//             run/stop/step FSM stops the channels only at phase boundaries,
//             so a high pulse is never cut short.
//  Ports    : fpgaGlobalClock   - sole clock
//             reset_i           - asynchronous active-high reset
//             run_i / halt_i    - run request level / forced stop (halt wins)
//             step_i            - one ch0 period while STOPPED
//             cfg_we_i, cfg_ch_i, cfg_high_i, cfg_low_i - shadow writes
//             clk_o, rise_o, fall_o - per-channel level and edge strobes
//             tick_o            - prescaler tick
//             state_o           - 0 STOPPED, 1 RUNNING, 2 STEPPING, 3 STOPPING
//  Revision : 1.0 - initial release
// ============================================================================
module multi_clock_tree_gen #(
    parameter int NR_CHANNELS  = 2,
    parameter int TICK_BITS    = 3,
    parameter int RELOAD_VALUE = 4,
    parameter int CNT_BITS     = 8,
    parameter int DEF_HIGH     = 1,
    parameter int DEF_LOW      = 1,
    parameter int RUN_AT_RESET = 1,
    localparam int CH_BITS     = (NR_CHANNELS > 1) ? $clog2(NR_CHANNELS) : 1
) (
    input  logic                   fpgaGlobalClock,
    input  logic                   reset_i,
    input  logic                   run_i,
    input  logic                   halt_i,
    input  logic                   step_i,
    input  logic                   cfg_we_i,
    input  logic [CH_BITS-1:0]     cfg_ch_i,
    input  logic [CNT_BITS-1:0]    cfg_high_i,
    input  logic [CNT_BITS-1:0]    cfg_low_i,
    output logic [NR_CHANNELS-1:0] clk_o,
    output logic [NR_CHANNELS-1:0] rise_o,
    output logic [NR_CHANNELS-1:0] fall_o,
    output logic                   tick_o,
    output logic [1:0]             state_o
);

    // ------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------
    localparam logic [1:0] c_ST_STOPPED  = 2'd0;
    localparam logic [1:0] c_ST_RUNNING  = 2'd1;
    localparam logic [1:0] c_ST_STEPPING = 2'd2;
    localparam logic [1:0] c_ST_STOPPING = 2'd3;
    localparam logic [1:0] c_ST_RESET    = (RUN_AT_RESET != 0) ? c_ST_RUNNING
                                                               : c_ST_STOPPED;

    localparam logic [TICK_BITS-1:0] c_RELOAD   = TICK_BITS'(RELOAD_VALUE);
    localparam logic [TICK_BITS-1:0] c_TICK_ONE = TICK_BITS'(1);
    localparam logic [CNT_BITS-1:0]  c_CNT_ONE  = CNT_BITS'(1);
    localparam logic [CNT_BITS-1:0]  c_DEF_HIGH = CNT_BITS'(DEF_HIGH);
    localparam logic [CNT_BITS-1:0]  c_DEF_LOW  = CNT_BITS'(DEF_LOW);
    // The first phase after reset is a low phase of DEF_LOW ticks; a zero
    // duration is stretched to one tick just like a programmed zero.
    localparam logic [CNT_BITS-1:0]  c_PC_RESET = (DEF_LOW == 0) ? c_CNT_ONE
                                                                 : c_DEF_LOW;

    // ------------------------------------------------------------------
    // Shared prescaler
    // ------------------------------------------------------------------
    logic [TICK_BITS-1:0] r_cnt_q;
    logic [TICK_BITS-1:0] w_cnt_d;
    logic                 w_tick;

    always_comb begin
        w_tick  = (r_cnt_q == '0);
        w_cnt_d = w_tick ? c_RELOAD : (r_cnt_q - c_TICK_ONE);
    end

    always_ff @(posedge fpgaGlobalClock or posedge reset_i) begin
        if (reset_i) begin
            r_cnt_q <= c_RELOAD;
        end else begin
            r_cnt_q <= w_cnt_d;
        end
    end

    // With RELOAD_VALUE=0 the counter sits at zero during reset, so the
    // visible tick is masked while reset is held.
    assign tick_o = w_tick & ~reset_i;

    // ------------------------------------------------------------------
    // Run/stop/step FSM
    // ------------------------------------------------------------------
    logic [1:0]             r_state_q;
    logic [1:0]             w_state_d;
    logic                   w_adv_all;   // every channel may advance
    logic                   w_stopping;  // only high channels may advance
    logic [NR_CHANNELS-1:0] w_level;
    logic                   w_ch0_fall;  // ch0 falls at the coming edge

    always_ff @(posedge fpgaGlobalClock or posedge reset_i) begin
        if (reset_i) begin
            r_state_q <= c_ST_RESET;
        end else begin
            r_state_q <= w_state_d;
        end
    end

    always_comb begin
        w_state_d = r_state_q;
        case (r_state_q)
            c_ST_STOPPED: begin
                if (run_i && !halt_i) begin
                    w_state_d = c_ST_RUNNING;
                end else if (step_i && !run_i && !halt_i) begin
                    w_state_d = c_ST_STEPPING;
                end
            end
            c_ST_RUNNING: begin
                if (!run_i || halt_i) begin
                    w_state_d = c_ST_STOPPING;
                end
            end
            c_ST_STEPPING: begin
                // Leave on the same edge that drops ch0, so that a tick in
                // the following cycle cannot start a second ch0 period.
                if (w_ch0_fall || halt_i) begin
                    w_state_d = c_ST_STOPPING;
                end
            end
            c_ST_STOPPING: begin
                if (run_i && !halt_i) begin
                    w_state_d = c_ST_RUNNING;
                end else if (w_level == '0) begin
                    w_state_d = c_ST_STOPPED;
                end
            end
            default: begin
                w_state_d = c_ST_STOPPED;
            end
        endcase
    end

    always_comb begin
        state_o    = r_state_q;
        w_adv_all  = (r_state_q == c_ST_RUNNING) || (r_state_q == c_ST_STEPPING);
        w_stopping = (r_state_q == c_ST_STOPPING);
    end

    // ------------------------------------------------------------------
    // Channels
    // ------------------------------------------------------------------
    // Channel indices are compared at full integer width, so an index at or
    // beyond NR_CHANNELS matches no channel and the write is dropped.
    logic [31:0] w_cfg_ch;
    assign w_cfg_ch = 32'(cfg_ch_i);

    for (genvar g = 0; g < NR_CHANNELS; g++) begin : g_ch
        logic                r_level_q, w_level_d;
        logic                r_rise_q,  w_rise_d;
        logic                r_fall_q,  w_fall_d;
        logic [CNT_BITS-1:0] r_pc_q,    w_pc_d;
        logic [CNT_BITS-1:0] r_high_q,  w_high_d;
        logic [CNT_BITS-1:0] r_low_q,   w_low_d;
        logic [CNT_BITS-1:0] w_high_eff;
        logic [CNT_BITS-1:0] w_low_eff;
        logic                w_cfg_hit;
        logic                w_adv;

        always_comb begin
            // Shadow registers: only read when a new phase is loaded, so a
            // write never shortens or stretches the phase in progress.
            w_cfg_hit = cfg_we_i && (w_cfg_ch == 32'(g));
            w_high_d  = w_cfg_hit ? cfg_high_i : r_high_q;
            w_low_d   = w_cfg_hit ? cfg_low_i  : r_low_q;

            w_high_eff = (r_high_q == '0) ? c_CNT_ONE : r_high_q;
            w_low_eff  = (r_low_q  == '0) ? c_CNT_ONE : r_low_q;

            // While stopping, a low channel stays frozen and a high channel
            // runs its high phase to completion.
            w_adv = w_tick && (w_adv_all || (w_stopping && r_level_q));

            w_level_d = r_level_q;
            w_pc_d    = r_pc_q;
            w_rise_d  = 1'b0;
            w_fall_d  = 1'b0;
            if (w_adv) begin
                if (r_pc_q <= c_CNT_ONE) begin
                    w_level_d = ~r_level_q;
                    w_pc_d    = r_level_q ? w_low_eff : w_high_eff;
                    w_rise_d  = ~r_level_q;
                    w_fall_d  = r_level_q;
                end else begin
                    w_pc_d = r_pc_q - c_CNT_ONE;
                end
            end
        end

        always_ff @(posedge fpgaGlobalClock or posedge reset_i) begin
            if (reset_i) begin
                r_level_q <= 1'b0;
                r_rise_q  <= 1'b0;
                r_fall_q  <= 1'b0;
                r_pc_q    <= c_PC_RESET;
                r_high_q  <= c_DEF_HIGH;
                r_low_q   <= c_DEF_LOW;
            end else begin
                r_level_q <= w_level_d;
                r_rise_q  <= w_rise_d;
                r_fall_q  <= w_fall_d;
                r_pc_q    <= w_pc_d;
                r_high_q  <= w_high_d;
                r_low_q   <= w_low_d;
            end
        end

        assign clk_o[g]   = r_level_q;
        assign rise_o[g]  = r_rise_q;
        assign fall_o[g]  = r_fall_q;
        assign w_level[g] = r_level_q;

        if (g == 0) begin : g_ch0
            assign w_ch0_fall = w_fall_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_multi_clock_tree_gen.sv
`default_nettype none
// ============================================================================
//  Module   : tb_multi_clock_tree_gen
//  Purpose  : Self-checking bench for multi_clock_tree_gen (3 channels,
//             reload 4). Table-driven reset/start timing, directed sequences
//             for reconfiguration, stop, step and reset, and randomized runs
//             checked against an arithmetic edge-time model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_multi_clock_tree_gen;

    localparam int NCH = 3;
    localparam int PER = 5;   // RELOAD_VALUE + 1

    logic           clk      = 1'b0;
    logic           reset_i  = 1'b1;
    logic           run_i    = 1'b1;
    logic           halt_i   = 1'b0;
    logic           step_i   = 1'b0;
    logic           cfg_we_i = 1'b0;
    logic [1:0]     cfg_ch_i = 2'd0;
    logic [7:0]     cfg_high_i = 8'd0;
    logic [7:0]     cfg_low_i  = 8'd0;
    logic [NCH-1:0] clk_o, rise_o, fall_o;
    logic           tick_o;
    logic [1:0]     state_o;

    int cyc     = 0;
    int n_tests = 0;
    int n_fail  = 0;

    // Random-run model context
    int m_h[NCH];
    int m_l[NCH];
    int e_r = 0;
    int e_s = 0;

    typedef struct {
        int         cyc;
        logic       run;
        logic [2:0] e_clk;
        logic [2:0] e_rise;
        logic [2:0] e_fall;
        logic       e_tick;
        logic [1:0] e_st;
    } vec_t;
    vec_t tbl[11];

    multi_clock_tree_gen #(
        .NR_CHANNELS (NCH),
        .TICK_BITS   (3),
        .RELOAD_VALUE(4),
        .CNT_BITS    (8),
        .DEF_HIGH    (1),
        .DEF_LOW     (1),
        .RUN_AT_RESET(1)
    ) dut (
        .fpgaGlobalClock(clk),
        .reset_i        (reset_i),
        .run_i          (run_i),
        .halt_i         (halt_i),
        .step_i         (step_i),
        .cfg_we_i       (cfg_we_i),
        .cfg_ch_i       (cfg_ch_i),
        .cfg_high_i     (cfg_high_i),
        .cfg_low_i      (cfg_low_i),
        .clk_o          (clk_o),
        .rise_o         (rise_o),
        .fall_o         (fall_o),
        .tick_o         (tick_o),
        .state_o        (state_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got 0x%0h, want 0x%0h", name, cyc, act, exp);
        end
    endtask

    // Advance to just after the next rising edge; cyc then names that edge.
    task automatic step_cyc();
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic do_reset(input logic run);
        reset_i  = 1'b1;
        run_i    = run;
        halt_i   = 1'b0;
        step_i   = 1'b0;
        cfg_we_i = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_i = 1'b0;
        cyc     = 0;
    endtask

    task automatic cfg_write(input int ch, input int h, input int l);
        cfg_we_i   = 1'b1;
        cfg_ch_i   = ch[1:0];
        cfg_high_i = h[7:0];
        cfg_low_i  = l[7:0];
        step_cyc();
        cfg_we_i   = 1'b0;
    endtask

    task automatic run_table();
        for (int i = 0; i < 11; i++) begin
            while (cyc < tbl[i].cyc) step_cyc();
            run_i = tbl[i].run;
            chk("tbl_clk",   32'(clk_o),   32'(tbl[i].e_clk));
            chk("tbl_rise",  32'(rise_o),  32'(tbl[i].e_rise));
            chk("tbl_fall",  32'(fall_o),  32'(tbl[i].e_fall));
            chk("tbl_tick",  32'(tick_o),  32'(tbl[i].e_tick));
            chk("tbl_state", 32'(state_o), 32'(tbl[i].e_st));
        end
    endtask

    // ---------------- reference model (edge times from tick counts) -------
    // Ticks advance channels at edges j with j % PER == 0.
    function automatic int ticks_in(int a, int b);
        if (b < a) return 0;
        return (b / PER) - ((a - 1) / PER);
    endfunction

    // Level after n advancing ticks from a fresh low phase of one tick:
    // first tick rises, then h ticks high, l ticks low, repeating.
    function automatic logic lvl_run(int n, int h, int l);
        if (n == 0) return 1'b0;
        return ((n - 1) % (h + l)) < h;
    endfunction

    function automatic logic exp_lvl(int ch, int k);
        int h = (m_h[ch] == 0) ? 1 : m_h[ch];
        int l = (m_l[ch] == 0) ? 1 : m_l[ch];
        int n_run;
        int p;
        if (k <= e_s + 1) return lvl_run(ticks_in(e_r + 2, k), h, l);
        n_run = ticks_in(e_r + 2, e_s + 1);
        if (!lvl_run(n_run, h, l)) return 1'b0;
        p = (n_run - 1) % (h + l);
        return ticks_in(e_s + 2, k) < (h - p);
    endfunction

    function automatic logic [NCH-1:0] exp_vec(int k);
        logic [NCH-1:0] v;
        for (int c = 0; c < NCH; c++) v[c] = exp_lvl(c, k);
        return v;
    endfunction

    function automatic logic [1:0] exp_state(int k);
        if (k <= e_r)     return 2'd0;
        if (k <= e_s)     return 2'd1;
        if (k == e_s + 1) return 2'd3;
        return (exp_vec(k - 1) != '0) ? 2'd3 : 2'd0;
    endfunction

    initial begin
        int rq[$];
        int fq[$];
        int cnt;
        int nr;
        int nf;
        int guard;
        logic e0;
        logic e12;
        logic [NCH-1:0] ev;
        logic [NCH-1:0] evp;

        //            cyc run  clk     rise    fall    tick  state
        tbl[0]  = '{0,  1'b1, 3'b000, 3'b000, 3'b000, 1'b0, 2'd1};
        tbl[1]  = '{1,  1'b1, 3'b000, 3'b000, 3'b000, 1'b0, 2'd1};
        tbl[2]  = '{4,  1'b1, 3'b000, 3'b000, 3'b000, 1'b1, 2'd1};
        tbl[3]  = '{5,  1'b1, 3'b111, 3'b111, 3'b000, 1'b0, 2'd1};
        tbl[4]  = '{6,  1'b1, 3'b111, 3'b000, 3'b000, 1'b0, 2'd1};
        tbl[5]  = '{9,  1'b1, 3'b111, 3'b000, 3'b000, 1'b1, 2'd1};
        tbl[6]  = '{10, 1'b1, 3'b000, 3'b000, 3'b111, 1'b0, 2'd1};
        tbl[7]  = '{11, 1'b1, 3'b000, 3'b000, 3'b000, 1'b0, 2'd1};
        tbl[8]  = '{14, 1'b1, 3'b000, 3'b000, 3'b000, 1'b1, 2'd1};
        tbl[9]  = '{15, 1'b1, 3'b111, 3'b111, 3'b000, 1'b0, 2'd1};
        tbl[10] = '{16, 1'b1, 3'b111, 3'b000, 3'b000, 1'b0, 2'd1};

        // ---- start-up timing -------------------------------------------
        do_reset(1'b1);
        run_table();

        // ---- ch1 rewritten mid-high-phase (high since 15) ---------------
        cfg_write(1, 3, 2);
        while (cyc < 60) begin
            step_cyc();
            if (rise_o[1]) rq.push_back(cyc);
            if (fall_o[1]) fq.push_back(cyc);
        end
        chk("ch1_nrise", 32'(rq.size()), 2);
        chk("ch1_nfall", 32'(fq.size()), 2);
        chk("ch1_fall0", (fq.size() > 0) ? fq[0] : -1, 20);
        chk("ch1_rise0", (rq.size() > 0) ? rq[0] : -1, 30);
        chk("ch1_fall1", (fq.size() > 1) ? fq[1] : -1, 45);
        chk("ch1_rise1", (rq.size() > 1) ? rq[1] : -1, 55);

        // ---- stop request while ch0 (high=4) is high ---------------------
        do_reset(1'b1);
        cfg_write(0, 4, 1);
        while (cyc < 6) step_cyc();
        run_i = 1'b0;
        step_cyc();
        chk("stop_state_stopping", 32'(state_o), 3);
        while (cyc < 24) step_cyc();
        chk("stop_ch0_still_high", 32'(clk_o[0]), 1);
        step_cyc();
        chk("stop_ch0_fall", 32'(fall_o[0]), 1);
        chk("stop_ch0_low", 32'(clk_o[0]), 0);
        step_cyc();
        chk("stop_state_stopped", 32'(state_o), 0);
        cnt = 0;
        repeat (200) begin
            step_cyc();
            if ((rise_o | fall_o | clk_o) != '0) cnt++;
        end
        chk("stop_quiet_200", cnt, 0);
        chk("stop_state_final", 32'(state_o), 0);

        // ---- step: halted step does nothing, then one ch0 period ---------
        halt_i = 1'b1;
        step_i = 1'b1;
        step_cyc();
        step_i = 1'b0;
        halt_i = 1'b0;
        cnt = 0;
        repeat (20) begin
            step_cyc();
            if ((rise_o | fall_o) != '0) cnt++;
        end
        chk("halt_step_edges", cnt, 0);
        chk("halt_step_state", 32'(state_o), 0);

        step_i = 1'b1;
        step_cyc();
        step_i = 1'b0;
        chk("step_state_stepping", 32'(state_o), 2);
        nr = 0;
        nf = 0;
        guard = 0;
        while (state_o != 2'd0 && guard < 300) begin
            step_cyc();
            guard++;
            nr += int'(rise_o[0]);
            nf += int'(fall_o[0]);
        end
        chk("step_done_in_time", 32'(guard < 300), 1);
        repeat (30) begin
            step_cyc();
            nr += int'(rise_o[0]);
            nf += int'(fall_o[0]);
        end
        chk("step_rise_count", nr, 1);
        chk("step_fall_count", nf, 1);
        chk("step_state_end", 32'(state_o), 0);

        // ---- asynchronous reset while ch0 is high ------------------------
        do_reset(1'b1);
        while (cyc < 6) step_cyc();
        chk("rst_pre_high", 32'(clk_o), 32'(3'b111));
        reset_i = 1'b1;
        #1;
        chk("rst_clk_cleared", 32'(clk_o), 0);
        chk("rst_no_fall", 32'(fall_o), 0);
        chk("rst_state", 32'(state_o), 1);
        repeat (3) begin
            @(posedge clk);
            #1;
            chk("rst_hold_no_fall", 32'(fall_o), 0);
        end
        @(negedge clk);
        reset_i = 1'b0;
        cyc = 0;
        run_table();

        // ---- zero high duration, and out-of-range channel write ----------
        cfg_write(0, 0, 3);
        cfg_write(3, 7, 7);
        while (cyc < 60) begin
            step_cyc();
            e0  = (cyc < 20) || (cyc >= 35 && cyc < 40) || (cyc >= 55 && cyc < 60);
            e12 = ((cyc / PER) % 2) == 1;
            chk("cfg_zero_vec", 32'(clk_o), 32'({e12, e12, e0}));
        end

        // ---- randomized runs against the edge-time model ----------------
        for (int it = 0; it < 3; it++) begin
            do_reset(1'b0);
            step_cyc();
            step_cyc();
            chk("rnd_stopped", 32'(state_o), 0);
            for (int c = 0; c < NCH; c++) begin
                m_h[c] = int'($urandom_range(0, 6));
                m_l[c] = int'($urandom_range(0, 6));
                cfg_write(c, m_h[c], m_l[c]);
            end
            repeat (int'($urandom_range(0, 7))) step_cyc();
            e_r   = cyc;
            e_s   = e_r + 100 + int'($urandom_range(0, 200));
            run_i = 1'b1;
            while (cyc < e_s + 150) begin
                step_cyc();
                ev  = exp_vec(cyc);
                evp = exp_vec(cyc - 1);
                chk("rnd_clk",   32'(clk_o),   32'(ev));
                chk("rnd_rise",  32'(rise_o),  32'(ev & ~evp));
                chk("rnd_fall",  32'(fall_o),  32'(~ev & evp));
                chk("rnd_tick",  32'(tick_o),  32'((cyc % PER) == PER - 1));
                chk("rnd_state", 32'(state_o), 32'(exp_state(cyc)));
                if (cyc == e_s) run_i = 1'b0;
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
